encoder_speed_meter: RTL and testbench
======================================

# encoder_speed_meter

Feedback-side counterpart of the PID output stage: it measures four quadrature-encoder motor shafts and streams signed RPM samples to the PID controller. It uses the same `valid`/`chn`/`data` channel-multiplexed stream format that the PID output stage consumes, with the same channel numbering as the motor PWM outputs. Each window it latches per-channel edge counts, scales them to RPM and emits channels 0..3 on consecutive cycles.

## Interface
- `DATA_WIDTH`, 16, width of the signed RPM output (two's complement).
- `NUM_CHN`, 4, number of encoder channels (fixed at 4).
- `CHN_WIDTH`, 3, localparam, channel index width.
- `CLK_FREQ`, 27_000_000, clock frequency in Hz.
- `SAMPLE_FREQ`, 100, measurement window rate in Hz.
  - `WINDOW_CYCLES` = `CLK_FREQ/SAMPLE_FREQ` = 270000.
- `ENC_CPR`, 1320, quadrature edges (x4) per output-shaft revolution.
- `clk`  in  1  system clock, single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `enc_0_a`, `enc_0_b` … `enc_3_a`, `enc_3_b`  in  1 each  raw encoder phases; asynchronous to `clk`.
- `y_valid_o`  out  1  sample strobe.
- `y_chn_o`  out  `CHN_WIDTH`  channel index of the current sample.
- `y_data_o`  out  `DATA_WIDTH`  signed RPM; positive means A leads B (forward).

## Operation
- **Input synchronisation:** every phase input passes through a 2-FF synchronizer, then a third register holds the previous sample for edge detection.
- **x4 decode (per channel):** compare previous {A,B} with current {A,B}.
  - Gray sequence 00→10→11→01→00 gives +1.
  - The reverse sequence gives −1.
  - No change gives 0.
  - A double change (both phases toggle together) gives 0 and is ignored.
- **Edge counter:** signed, `DATA_WIDTH` bits per channel. It saturates at +32767 / −32768 and never wraps.
- **Window timer:** counts 0..`WINDOW_CYCLES`−1 and wraps. On the cycle it equals `WINDOW_CYCLES`−1 (the tick):
  - all four counts are copied to snapshot registers;
  - the counters are reloaded with that cycle's decode increment, not zero, so no edge is lost at the window boundary.
- **Scaling:**
  - rpm = sign(cnt) × ((|cnt| × 60 × `SAMPLE_FREQ`) / `ENC_CPR`).
  - Division truncates toward zero, computed on the magnitude.
  - The intermediate is at least 32 bits unsigned.
  - The result saturates to ±(2^(`DATA_WIDTH`−1)−1); −32768 is never output.
- **Sequencer states:**
  - IDLE → SCALE on tick.
  - SCALE → EMIT after one cycle; all four products are registered in SCALE.
  - EMIT outputs ch0, ch1, ch2, ch3 on successive cycles, then returns to IDLE.
- **Output hold:** `y_chn_o` and `y_data_o` hold their last values while `y_valid_o` is low.
- **Reset:**
  - All outputs reset to 0.
  - The synchronizers, counters, snapshots, timer and FSM reset to 0 / IDLE.
  - Reset mid-burst aborts the burst with no partial continuation.
  - The first tick occurs `WINDOW_CYCLES` cycles after `rstn` deasserts.

## Timing
- Input-to-decode latency: 3 cycles, from an encoder pin change to its counter update.
- Tick at cycle T. SCALE at T+1. `y_valid_o`=1 during T+2..T+5 with `y_chn_o`=0,1,2,3 respectively.
- Exactly 4 valid cycles per window. The burst (4 cycles) is always shorter than the window, so bursts never overlap.
- The stream has no backpressure; the consumer must accept every valid cycle.
- An edge whose decode lands on the tick cycle is counted in the next window.

## Structure
- **Shared package `tdps_pkg`:** `DATA_WIDTH`, `CHN_WIDTH`, `NUM_CHN` and `RPM_MAX` (1500), shared with the PID output stage and the PID core.
  - `WINDOW_CYCLES` and the scale constant 60×`SAMPLE_FREQ` are derived locally as localparams.
- **Sub-module `quad_decoder`**, instantiated four times.
  - Inputs: `clk`, `rstn`, `a`, `b`, `clr`.
  - Contents: synchronizer, prev-state register, increment logic and saturating counter.
  - Outputs: `cnt` (signed `DATA_WIDTH`). `clr` performs the reload-with-increment.
- **Top level:** window timer, snapshot registers, scaler and sequencer.

## Test plan
- **Reset:**
  - Stimulus: hold `rstn`=0 with toggling encoders.
  - Required: all outputs 0, no `y_valid_o`.
  - Stimulus: release reset.
  - Required: first valid burst at exactly `WINDOW_CYCLES`+2 cycles.
- **Forward:** 330 forward edges evenly spaced within one window → burst shows ch0=+1500; ch1..3 idle = 0.
- **Reverse:** 165 reverse edges on ch2 → ch2 = −750, with `y_chn_o` sequence 0,1,2,3 on T+2..T+5.
- **Invalid transition:** 100 forward edges on ch1 plus 10 injected 00↔11 double changes → ch1 = 100×6000/1320 = 454 (truncated).
- **Boundary edge:** a single forward edge decoded on the tick cycle → current window reports 0, next window reports +4 (1×6000/1320 = 4).
- **Saturation:** one forward edge every cycle for a full window on ch3 → counter pins at 32767; output = +32767 with no wrap. Then reset asserted mid-burst (T+3) → `y_valid_o` drops immediately and outputs are 0.

Source files
------------

// File: rtl/tdps_pkg.sv
// tdps_pkg: stream format constants shared by the PID core, PID output stage and encoder speed meter
package tdps_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int CHN_WIDTH  = 3;
   localparam int NUM_CHN    = 4;
   localparam int RPM_MAX    = 1500;
   typedef enum logic [1:0] {IDLE, SCALE, EMIT} seq_state_e;
endpackage

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised x4 quadrature decode into a saturating signed edge counter
module quad_decoder
   import tdps_pkg::*;
#(
   parameter int CNT_WIDTH = DATA_WIDTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        a,
   input  logic                        b,
   input  logic                        clr,
   output logic signed [CNT_WIDTH-1:0] cnt
);
   localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
   localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
   logic [1:0] sync1_q, sync2_q, prev_q;
   logic [1:0] pos_cur, pos_prev, diff;
   logic up, dn;
   logic signed [CNT_WIDTH-1:0] step, cnt_q, cnt_d;
   // Gray {A,B} 00,10,11,01 mapped to phase positions 0..3; a jump of 2 is a double change
   assign pos_cur  = {sync2_q[0], sync2_q[1] ^ sync2_q[0]};
   assign pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
   assign diff     = pos_cur - pos_prev;
   assign up       = diff == 2'd1;
   assign dn       = diff == 2'd3;
   assign step     = up ? CNT_WIDTH'(1) : dn ? '1 : '0;
   assign cnt_d    = clr ? step
                   : ((up && cnt_q == CNT_MAX) || (dn && cnt_q == CNT_MIN)) ? cnt_q : cnt_q + step;
   assign cnt      = cnt_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= {a, b};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/encoder_speed_meter.sv
// encoder_speed_meter: per-window edge counts of four quadrature encoders scaled to signed RPM,
// streamed as channels 0..3 on consecutive valid cycles
module encoder_speed_meter
   import tdps_pkg::*;
#(
   parameter int DATA_WIDTH  = tdps_pkg::DATA_WIDTH,
   parameter int NUM_CHN     = tdps_pkg::NUM_CHN,
   parameter int CLK_FREQ    = 27_000_000,
   parameter int SAMPLE_FREQ = 100,
   parameter int ENC_CPR     = 1320,
   localparam int CHN_WIDTH  = tdps_pkg::CHN_WIDTH
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         enc_0_a,
   input  logic                         enc_0_b,
   input  logic                         enc_1_a,
   input  logic                         enc_1_b,
   input  logic                         enc_2_a,
   input  logic                         enc_2_b,
   input  logic                         enc_3_a,
   input  logic                         enc_3_b,
   output logic                         y_valid_o,
   output logic [CHN_WIDTH-1:0]         y_chn_o,
   output logic signed [DATA_WIDTH-1:0] y_data_o
);
   localparam int WINDOW_CYCLES     = CLK_FREQ / SAMPLE_FREQ;
   localparam int TW                = $clog2(WINDOW_CYCLES);
   localparam logic [31:0] RPM_SCALE = 32'(60 * SAMPLE_FREQ);
   localparam logic [31:0] CPR       = 32'(ENC_CPR);
   localparam logic [31:0] RPM_LIM   = 32'((1 << (DATA_WIDTH - 1)) - 1);
   logic [NUM_CHN-1:0] enc_a, enc_b;
   logic [TW-1:0] timer_q, timer_d;
   logic tick;
   logic signed [DATA_WIDTH-1:0] cnt [NUM_CHN];
   logic signed [DATA_WIDTH-1:0] snap_q [NUM_CHN];
   logic signed [DATA_WIDTH-1:0] rpm_q [NUM_CHN];
   logic signed [DATA_WIDTH-1:0] rpm_d [NUM_CHN];
   seq_state_e state_q, state_d;
   logic [1:0] idx_q, idx_d, idx_nx;
   logic y_valid_q, y_valid_d;
   logic [CHN_WIDTH-1:0] y_chn_q, y_chn_d;
   logic signed [DATA_WIDTH-1:0] y_data_q, y_data_d;
   assign enc_a     = {enc_3_a, enc_2_a, enc_1_a, enc_0_a};
   assign enc_b     = {enc_3_b, enc_2_b, enc_1_b, enc_0_b};
   assign tick      = timer_q == TW'(WINDOW_CYCLES - 1);
   assign timer_d   = tick ? '0 : timer_q + TW'(1);
   assign y_valid_o = y_valid_q;
   assign y_chn_o   = y_chn_q;
   assign y_data_o  = y_data_q;
   for (genvar i = 0; i < NUM_CHN; i++) begin : g_dec
      quad_decoder #(.CNT_WIDTH(DATA_WIDTH)) u_dec (
         .clk  (clk),
         .rstn (rstn),
         .a    (enc_a[i]),
         .b    (enc_b[i]),
         .clr  (tick),
         .cnt  (cnt[i])
      );
   end
   // Scale on the magnitude so division truncates toward zero; -32768 can never be produced
   function automatic logic signed [DATA_WIDTH-1:0] to_rpm(input logic signed [DATA_WIDTH-1:0] c);
      logic signed [31:0] cx;
      logic [31:0] q;
      cx = 32'(c);
      q  = ($unsigned(cx < 0 ? -cx : cx) * RPM_SCALE) / CPR;
      q  = q > RPM_LIM ? RPM_LIM : q;
      return c[DATA_WIDTH-1] ? -DATA_WIDTH'(q) : DATA_WIDTH'(q);
   endfunction
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      idx_nx    = idx_q + 2'd1;
      y_valid_d = 1'b0;
      y_chn_d   = y_chn_q;
      y_data_d  = y_data_q;
      for (int k = 0; k < NUM_CHN; k++) rpm_d[k] = state_q == SCALE ? to_rpm(snap_q[k]) : rpm_q[k];
      if (state_q == IDLE) begin
         state_d = tick ? SCALE : IDLE;
      end else if (state_q == SCALE) begin
         state_d   = EMIT;
         idx_d     = '0;
         y_valid_d = 1'b1;
         y_chn_d   = '0;
         y_data_d  = rpm_d[0];
      end else begin
         state_d   = idx_q == 2'd3 ? IDLE : EMIT;
         idx_d     = idx_nx;
         y_valid_d = idx_q != 2'd3;
         y_chn_d   = idx_q == 2'd3 ? y_chn_q : CHN_WIDTH'(idx_nx);
         y_data_d  = idx_q == 2'd3 ? y_data_q : rpm_q[idx_nx];
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timer_q   <= '0;
         snap_q    <= '{default: '0};
         rpm_q     <= '{default: '0};
         state_q   <= IDLE;
         idx_q     <= '0;
         y_valid_q <= 1'b0;
         y_chn_q   <= '0;
         y_data_q  <= '0;
      end else begin
         timer_q   <= timer_d;
         if (tick) snap_q <= cnt;
         rpm_q     <= rpm_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         y_valid_q <= y_valid_d;
         y_chn_q   <= y_chn_d;
         y_data_q  <= y_data_d;
      end
   end
endmodule

// File: tb/tb_encoder_speed_meter.sv
// tb_encoder_speed_meter: randomized quadrature traffic against a per-window edge-count model
module tb_encoder_speed_meter;
   localparam int W   = 33000;
   localparam int SF  = 100;
   localparam int CPR = 1320;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [3:0] ea = '0, eb = '0;
   logic y_valid_o;
   logic [2:0] y_chn_o;
   logic signed [15:0] y_data_o;
   int cyc;
   int checks = 0, errors = 0;
   int pos [4];
   int exp_cnt [3][4];
   always #5 clk = ~clk;
   always @(posedge clk or negedge rstn) cyc <= !rstn ? 0 : cyc + 1;
   encoder_speed_meter #(.CLK_FREQ(W * SF), .SAMPLE_FREQ(SF), .ENC_CPR(CPR)) dut (
      .clk(clk), .rstn(rstn),
      .enc_0_a(ea[0]), .enc_0_b(eb[0]), .enc_1_a(ea[1]), .enc_1_b(eb[1]),
      .enc_2_a(ea[2]), .enc_2_b(eb[2]), .enc_3_a(ea[3]), .enc_3_b(eb[3]),
      .y_valid_o(y_valid_o), .y_chn_o(y_chn_o), .y_data_o(y_data_o)
   );
   function automatic int ref_rpm(int c);
      longint m, q;
      m = c < 0 ? -c : c;
      q = m * 60 * SF / CPR;
      if (q > 32767) q = 32767;
      return int'(c < 0 ? -q : q);
   endfunction
   // An edge decodes two cycles after it is driven; a decode on the tick belongs to the next window
   task automatic step(int ch, int dir);
      int w, v;
      if (dir == 2) pos[ch] = (pos[ch] + 2) % 4;
      else begin
         pos[ch] = (pos[ch] + dir + 4) % 4;
         w = (cyc + 3) / W;
         v = exp_cnt[w][ch] + dir;
         exp_cnt[w][ch] = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
      end
      ea[ch] = pos[ch] == 1 || pos[ch] == 2;
      eb[ch] = pos[ch] >= 2;
   endtask
   task automatic test_reset;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ea = 4'($urandom);
         eb = 4'($urandom);
         checks += 3;
         if (y_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", y_valid_o); end
         if (y_chn_o !== 3'd0) begin errors++; $display("FAIL reset_chn got=%0d want=0", y_chn_o); end
         if (y_data_o !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d want=0", y_data_o); end
      end
      ea = '0;
      eb = '0;
      for (int c = 0; c < 4; c++) pos[c] = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
   endtask
   task automatic check_burst(int w);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checks += 3;
         if (y_valid_o !== 1'b1) begin errors++; $display("FAIL burst%0d_valid ch%0d cyc=%0d got=%b want=1", w, k, cyc, y_valid_o); end
         if (y_chn_o !== 3'(k)) begin errors++; $display("FAIL burst%0d_chn got=%0d want=%0d", w, y_chn_o, k); end
         if (y_data_o !== 16'(ref_rpm(exp_cnt[w][k]))) begin
            errors++;
            $display("FAIL burst%0d_data ch%0d got=%0d want=%0d", w, k, y_data_o, ref_rpm(exp_cnt[w][k]));
         end
      end
      @(negedge clk);
      checks += 3;
      if (y_valid_o !== 1'b0) begin errors++; $display("FAIL burst%0d_end_valid got=%b want=0", w, y_valid_o); end
      if (y_chn_o !== 3'd3) begin errors++; $display("FAIL burst%0d_hold_chn got=%0d want=3", w, y_chn_o); end
      if (y_data_o !== 16'(ref_rpm(exp_cnt[w][3]))) begin
         errors++;
         $display("FAIL burst%0d_hold_data got=%0d want=%0d", w, y_data_o, ref_rpm(exp_cnt[w][3]));
      end
   endtask
   // Forward ch0, forward+double changes ch1, reverse ch2, edge every cycle ch3, plus one edge decoded on the tick
   task automatic test_traffic;
      int q0[$], q1[$], q1d[$], q2[$];
      int s3, early;
      early = -1;
      s3 = 40 + int'($urandom_range(0, 20));
      for (int k = 0; k < 330; k++) q0.push_back(100 + k * 90 + int'($urandom_range(0, 20)));
      for (int k = 0; k < 100; k++) q1.push_back(200 + k * 250);
      for (int k = 0; k < 10; k++) q1d.push_back(260 + k * 2500 + int'($urandom_range(0, 30)));
      for (int k = 0; k < 165; k++) q2.push_back(300 + k * 180 + int'($urandom_range(0, 20)));
      while (cyc < W + 1) begin
         if (q0.size() > 0 && q0[0] == cyc) begin void'(q0.pop_front()); step(0, 1); end
         if (q1.size() > 0 && q1[0] == cyc) begin void'(q1.pop_front()); step(1, 1); end
         if (q1d.size() > 0 && q1d[0] == cyc) begin void'(q1d.pop_front()); step(1, 2); end
         if (q2.size() > 0 && q2[0] == cyc) begin void'(q2.pop_front()); step(2, -1); end
         if (cyc >= s3 && cyc < 32900) step(3, 1);
         if (cyc == W - 3) step(0, 1);
         if (y_valid_o && early < 0) early = cyc;
         @(negedge clk);
      end
      checks++;
      if (early >= 0) begin errors++; $display("FAIL first_burst_early got_cyc=%0d want_cyc=%0d", early, W + 1); end
      check_burst(0);
   endtask
   task automatic test_boundary_and_abort;
      int early;
      early = -1;
      while (cyc < 2 * W + 1) begin
         if (y_valid_o && early < 0) early = cyc;
         @(negedge clk);
      end
      checks++;
      if (early >= 0) begin errors++; $display("FAIL second_burst_early got_cyc=%0d want_cyc=%0d", early, 2 * W + 1); end
      for (int k = 0; k < 2; k++) begin
         if (k > 0) @(negedge clk);
         checks += 3;
         if (y_valid_o !== 1'b1) begin errors++; $display("FAIL burst1_valid ch%0d got=%b want=1", k, y_valid_o); end
         if (y_chn_o !== 3'(k)) begin errors++; $display("FAIL burst1_chn got=%0d want=%0d", y_chn_o, k); end
         if (y_data_o !== 16'(ref_rpm(exp_cnt[1][k]))) begin
            errors++;
            $display("FAIL burst1_data ch%0d got=%0d want=%0d", k, y_data_o, ref_rpm(exp_cnt[1][k]));
         end
      end
      rstn = 1'b0;
      #1;
      checks += 3;
      if (y_valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", y_valid_o); end
      if (y_chn_o !== 3'd0) begin errors++; $display("FAIL abort_chn got=%0d want=0", y_chn_o); end
      if (y_data_o !== 16'sd0) begin errors++; $display("FAIL abort_data got=%0d want=0", y_data_o); end
      early = 0;
      repeat (10) begin
         @(negedge clk);
         if (y_valid_o !== 1'b0 || y_data_o !== 16'sd0) early++;
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL abort_resume got=%0d active cycles want=0", early); end
   endtask
   initial begin
      for (int w = 0; w < 3; w++) for (int c = 0; c < 4; c++) exp_cnt[w][c] = 0;
      test_reset();
      test_traffic();
      test_boundary_and_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
